// File: rtl/tvp_gen_pkg.sv
// Shared constants and helpers for the TVP decoder stream emulator.
package tvp_gen_pkg;

  localparam int VIDEO_W = 10;

  // Test pattern selected by the MODE input.
  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  localparam logic [VIDEO_W-1:0] BLACK_LEVEL = 10'd64;
  localparam logic [VIDEO_W-1:0] WHITE_LEVEL = 10'd940;

  // Horizontal ramp: black plus the low 9 bits of the pixel index, clipped at white.
  function automatic logic [VIDEO_W-1:0] ramp_level(input logic [8:0] i_h);
    logic [VIDEO_W:0] w_sum;
    w_sum = {2'b00, i_h} + {1'b0, BLACK_LEVEL};
    return (w_sum > {1'b0, WHITE_LEVEL}) ? WHITE_LEVEL : w_sum[VIDEO_W-1:0];
  endfunction

endpackage

// File: rtl/pix_clk_en.sv
// Pixel-rate clock enable: one-cycle CLK_EN every PIX_DIV enabled clocks.
// The divider freezes while ENABLE is low so the raster can pause and resume.
module pix_clk_en #(
  parameter int PIX_DIV = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic ENABLE,
  output logic CLK_EN
);

  localparam int D_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [D_W-1:0] DIV_LAST = D_W'(PIX_DIV - 1);

  logic [D_W-1:0] r_div_cnt;
  logic           w_div_last;

  assign w_div_last = (r_div_cnt == DIV_LAST);

  // Divider counter: 0..PIX_DIV-1, held while ENABLE is low.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (RST) begin
      r_div_cnt <= '0;
    end else if (ENABLE) begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign CLK_EN = ENABLE && w_div_last;

endmodule

// File: rtl/tvp_stream_gen.sv
// TVP decoder output stream emulator: raster counters, pattern generator and
// registered HSYNC/VSYNC/luma outputs, all on a single clock with a pixel enable.
module tvp_stream_gen
  import tvp_gen_pkg::*;
#(
  parameter int PIX_DIV      = 5,
  parameter int H_ACTIVE     = 512,
  parameter int H_TOTAL      = 640,
  parameter int H_SYNC_START = 544,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_ACTIVE     = 384,
  parameter int V_TOTAL      = 408,
  parameter int V_SYNC_START = 390,
  parameter int V_SYNC_LEN   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic [1:0]         MODE,
  output logic               O_HS,
  output logic               O_VS,
  output logic [VIDEO_W-1:0] VIDEO,
  output logic               O_VISIBLE,
  output logic               FRAME_START
);

  // Counters are at least wide enough for the pattern bits they feed
  // (ramp uses h[8:0], checkerboard uses v[4]).
  localparam int H_W = ($clog2(H_TOTAL) > 9) ? $clog2(H_TOTAL) : 9;
  localparam int V_W = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;

  // Comparison constants carry one extra bit so sync-end == total still fits.
  localparam logic [H_W:0] H_LAST     = (H_W + 1)'(H_TOTAL - 1);
  localparam logic [H_W:0] H_ACT      = (H_W + 1)'(H_ACTIVE);
  localparam logic [H_W:0] HS_FIRST   = (H_W + 1)'(H_SYNC_START);
  localparam logic [H_W:0] HS_END     = (H_W + 1)'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [V_W:0] V_LAST     = (V_W + 1)'(V_TOTAL - 1);
  localparam logic [V_W:0] V_ACT      = (V_W + 1)'(V_ACTIVE);
  localparam logic [V_W:0] VS_FIRST   = (V_W + 1)'(V_SYNC_START);
  localparam logic [V_W:0] VS_END     = (V_W + 1)'(V_SYNC_START + V_SYNC_LEN);

  localparam bit PARAMS_OK =
      (PIX_DIV >= 1) &&
      (H_ACTIVE < H_TOTAL) && (H_SYNC_LEN > 0) &&
      (H_SYNC_START + H_SYNC_LEN <= H_TOTAL) &&
      (V_ACTIVE < V_TOTAL) && (V_SYNC_LEN > 0) &&
      (V_SYNC_START + V_SYNC_LEN <= V_TOTAL);

  // Raster state.
  logic [H_W-1:0]     r_h_cnt;
  logic [V_W-1:0]     r_v_cnt;
  mode_e              r_mode_q;
  logic               r_upd;

  // Output registers.
  logic               r_hs;
  logic               r_vs;
  logic [VIDEO_W-1:0] r_video;
  logic               r_visible;
  logic               r_frame_start;

  // Combinational decode of the current counter position.
  logic               w_pix_en;
  logic [H_W:0]       w_h_ext;
  logic [V_W:0]       w_v_ext;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_active;
  logic               w_hs_n;
  logic               w_vs_n;
  logic               w_origin;
  logic [VIDEO_W-1:0] w_video;

  pix_clk_en #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_clk_en (
    .CLK    (CLK),
    .RST    (RST),
    .ENABLE (ENABLE),
    .CLK_EN (w_pix_en)
  );

  assign w_h_ext  = {1'b0, r_h_cnt};
  assign w_v_ext  = {1'b0, r_v_cnt};
  assign w_h_last = (w_h_ext == H_LAST);
  assign w_v_last = (w_v_ext == V_LAST);
  assign w_active = (w_h_ext < H_ACT) && (w_v_ext < V_ACT);
  assign w_hs_n   = !((w_h_ext >= HS_FIRST) && (w_h_ext < HS_END));
  assign w_vs_n   = !((w_v_ext >= VS_FIRST) && (w_v_ext < VS_END));
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Horizontal/vertical raster counters; MODE is latched only at the frame wrap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_mode_q <= MODE_SOLID;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        if (w_v_last) begin
          r_v_cnt  <= '0;
          r_mode_q <= mode_e'(MODE);
        end else begin
          r_v_cnt <= r_v_cnt + 1'b1;
        end
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end
    end
  end

  // Pattern mux for the pixel the counters currently point at.
  always_comb begin
    // NOTE: default assigned first so every path drives w_video and no latch
    // is inferred.
    w_video = BLACK_LEVEL;
    if (w_active) begin
      unique case (r_mode_q)
        MODE_SOLID: w_video = WHITE_LEVEL;
        MODE_BARS:  w_video = r_h_cnt[5] ? WHITE_LEVEL : BLACK_LEVEL;
        MODE_CHECK: w_video = (r_h_cnt[4] ^ r_v_cnt[4]) ? WHITE_LEVEL : BLACK_LEVEL;
        MODE_RAMP:  w_video = ramp_level(r_h_cnt[8:0]);
      endcase
    end
  end

  // Output registers load one enabled clock after each pixel step, so the
  // power-on position (0,0) is never shown; FRAME_START is a single-clock pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_upd         <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_video       <= BLACK_LEVEL;
      r_visible     <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (ENABLE) begin
        r_upd <= w_pix_en;
        if (r_upd) begin
          r_hs          <= w_hs_n;
          r_vs          <= w_vs_n;
          r_video       <= w_video;
          r_visible     <= w_active;
          r_frame_start <= w_origin;
        end
      end
    end
  end

  assign O_HS        = r_hs;
  assign O_VS        = r_vs;
  assign VIDEO       = r_video;
  assign O_VISIBLE   = r_visible;
  assign FRAME_START = r_frame_start;

  // Raster geometry must be self-consistent; flagged in simulation only.
  a_params_legal: assert property (@(posedge CLK) PARAMS_OK);

endmodule

// File: doc/tvp_stream_gen.md
# tvp_stream_gen

Synthesizable source emulating the TVP decoder output stream: raster-timed HSYNC/VSYNC and 10-bit luma samples driven from a single clock. It drives the receive side (RX module, line buffer, TX) on the bench and on the board's debug header, so the capture path can be exercised without an HP instrument attached. It is the transmitting end of the interface that RX consumes.

## Interface
Parameters:
- PIX_DIV, 5: clocks per pixel; the pixel counter advances on a one-cycle enable every PIX_DIV clocks.
- H_ACTIVE, 512: visible pixels per line.
- H_TOTAL, 640: pixels per line.
- H_SYNC_START, 544: first pixel with HSYNC asserted.
- H_SYNC_LEN, 32: HSYNC width in pixels.
- V_ACTIVE, 384: visible lines per frame.
- V_TOTAL, 408: lines per frame.
- V_SYNC_START, 390: first line with VSYNC asserted.
- V_SYNC_LEN, 4: VSYNC width in lines.

Ports:
- CLK  in  1  system clock (TVP_CLK rate, 20 MHz).
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  high: raster runs; low: counters and outputs hold.
- MODE  in  2  pattern select: 0 solid white, 1 vertical bars, 2 checkerboard, 3 horizontal ramp.
- O_HS  out  1  horizontal sync, active low.
- O_VS  out  1  vertical sync, active low.
- VIDEO  out  10  luma sample.
- O_VISIBLE  out  1  high while VIDEO carries an active pixel.
- FRAME_START  out  1  one-clock pulse at pixel (0,0).

## Operation
- Divider: div_cnt counts 0..PIX_DIV-1 while ENABLE is high; pix_en = (div_cnt == PIX_DIV-1).
- On pix_en: h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync: O_HS is low for H_SYNC_START <= h_cnt < H_SYNC_START+H_SYNC_LEN. O_VS is low for V_SYNC_START <= v_cnt < V_SYNC_START+V_SYNC_LEN, over whole lines.
- Levels: BLACK = 10'd64, WHITE = 10'd940. Outside the active region VIDEO = BLACK.
- Patterns (active region only; h_cnt/v_cnt are the current pixel):
  - 0: WHITE.
  - 1: WHITE if h_cnt[5] else BLACK (32-pixel bars).
  - 2: WHITE if h_cnt[4]^v_cnt[4] else BLACK.
  - 3: BLACK + h_cnt[8:0], then saturate at WHITE (10-bit add, no wrap).
- MODE is sampled into mode_q only at the pix_en where the counters wrap to (0,0). A mid-frame change takes effect at the next frame.
- ENABLE low: div_cnt, h_cnt and v_cnt freeze and all outputs hold their last value. On re-enable, the raster resumes from the frozen position.
- Parameter legality: sync windows must lie inside the totals, and ACTIVE < TOTAL. Illegal values are not checked in RTL; an assertion in simulation covers them.

## Timing
- All outputs are registered. Outputs reflect the counter state one clock after the pix_en that produced it. Every output stays stable for exactly PIX_DIV clocks per pixel.
- FRAME_START goes high for one clock, on the clock where the outputs first show pixel (0,0).
- Reset values: O_HS=1, O_VS=1, VIDEO=BLACK, O_VISIBLE=0, FRAME_START=0, counters=0, mode_q=0.
- First pixel after reset release:
  - div_cnt reaches PIX_DIV-1 after PIX_DIV clocks.
  - The outputs show pixel (1,0) one clock later.
  - Pixel (0,0) of the first frame is never output. The first FRAME_START occurs at the first raster wrap.
- RST has priority over ENABLE. Reset mid-frame returns everything to the reset values on the next edge.
- Frame period: PIX_DIV*H_TOTAL*V_TOTAL clocks, which is 1,305,600 at the defaults.

## Structure
- Package tvp_gen_pkg holds:
  - MODE_SOLID/MODE_BARS/MODE_CHECK/MODE_RAMP
  - BLACK_LEVEL and WHITE_LEVEL
  - VIDEO_W = 10
- Sub-module pix_clk_en:
  - parameterised PIX_DIV divider
  - inputs CLK, RST, ENABLE; output CLK_EN
  - shared with RX-side sampling
- Raster counters, pattern mux and output registers stay in the top module.

## Test plan
- Reset, then ENABLE=1 and MODE=0:
  - O_HS low for exactly 32*5=160 clocks per line, with line period 3200 clocks.
  - O_VS low for 4 lines, with frame period 1,305,600 clocks.
- MODE=1: VIDEO is 64 for pixels 0–31, 940 for 32–63, and 64 again at 64. It is 64 whenever O_VISIBLE=0.
- MODE=3: VIDEO at pixel 0 is 64, at pixel 100 is 164, and at pixel 511 is 575. No value exceeds 940.
- MODE switched 0→2 at line 100:
  - the current frame stays solid through line 383
  - the checkerboard starts at the next FRAME_START
  - pixel (16,0)=940 and (16,16)=64
- ENABLE low for 1000 clocks mid-line: outputs and counters hold. After re-enable, the line completes with total active clocks still 2560.
- RST pulsed mid-frame: next clock O_HS=1, O_VS=1, VIDEO=64, O_VISIBLE=0. The raster restarts at (0,0) timing.
